instr_packer: RTL and testbench
===============================

INSTR_PACKER -- requirements
Module: instr_packer

Interface
REQ-001 Parameter BG_WIDTH, 2, bank-group field width.
REQ-002 Parameter BANK_WIDTH, 2, bank field width.
REQ-003 Parameter ROW_WIDTH, 17, row/column/PALL address field width.
REQ-004 Parameter FLUSH_TIMEOUT, 16, idle cycles before a partial beat closes; 0 disables timeout.
REQ-005 clk  input  1  single clock; all logic rising-edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 cmd_valid / cmd_ready  input / output  1 / 1  command handshake; a command is accepted on an edge with both high.
REQ-008 cmd_type  input  3  0=NOP, 1=PRE, 2=ACT, 3=RD, 4=WR, 5=REF, 6=ZQ; 7 is passed through unchanged.
REQ-009 cmd_bank / cmd_bg / cmd_addr  input  BANK_WIDTH / BG_WIDTH / ROW_WIDTH  address fields; cmd_addr[0] is the PALL flag for PRE.
REQ-010 cmd_wdata  input  512  burst data, sampled only with an accepted WR.
REQ-011 cmd_last  input  1  closes the beat after this command.
REQ-012 M_AXIS_TDATA / M_AXIS_TVALID / M_AXIS_TREADY  output / output / input  640 / 1 / 1  merged beat stream.
REQ-013 beat_count  output  32  beats transferred, wraps at 2^32.

Function
REQ-014 Slot format: [2:0] type, [4:3] bank, [6:5] bg, [23:7] addr, [31:24] zero.
REQ-015 Beat format: TDATA[32*i+31:32*i] is slot i for i=0..3; TDATA[639:128] is write data.
REQ-016 Accepted commands fill slots in arrival order, starting at slot 0.
REQ-017 Unfilled slots are all-zero (NOP); a beat holding no WR carries zero write data.
REQ-018 A beat holds at most one WR; its cmd_wdata is the beat's write data.
REQ-019 State ACC: assemble; slot count 0..3; has_wr flag; idle counter.
REQ-020 State HOLD: closed beat is waiting for the output register; cmd_ready is 0.
REQ-021 cmd_ready = rst_n AND state==ACC AND NOT (cmd_valid AND cmd_type==WR AND has_wr).
REQ-022 Close causes: the 4th slot is accepted; cmd_last is accepted; WR conflict (REQ-021 blocked WR, slot count > 0); idle counter reaches FLUSH_TIMEOUT with slot count > 0.
REQ-023 Output register free = NOT M_AXIS_TVALID OR M_AXIS_TREADY.
- Close with output free: the beat, including any command accepted that edge, loads into the output register; assembly clears; state stays ACC.
- Close with output not free: go to HOLD.
REQ-024 HOLD -> ACC on the first edge the output is free; the beat loads and the assembly clears.
REQ-025 Latency: command accepted at edge N that closes the beat -> M_AXIS_TVALID high after edge N if the output is free.
REQ-026 A blocked WR is accepted at the first edge after its conflict closure with cmd_ready high, into slot 0 of a fresh beat.
REQ-027 M_AXIS_TVALID stays high and TDATA stays stable until M_AXIS_TREADY; it drops after the handshake unless a new beat loads on that edge.
REQ-028 Idle counter:
- clears on any acceptance and on closure;
- increments each ACC cycle with slot count > 0 and no acceptance;
- saturates at FLUSH_TIMEOUT.
REQ-029 Acceptance and timeout on the same edge: acceptance wins; close only if another REQ-022 cause applies.
REQ-030 Slot count 0 never produces a beat, whether from cmd_last idle or timeout.
REQ-031 beat_count increments on each M_AXIS_TVALID AND M_AXIS_TREADY edge.

Reset
REQ-032 rst_n low immediately sets: state ACC, slot count 0, has_wr 0, idle counter 0, M_AXIS_TVALID 0, M_AXIS_TDATA 0, beat_count 0; cmd_ready is 0 while rst_n is low.
REQ-033 Reset mid-beat or mid-HOLD discards partial and pending beats without emitting them.
REQ-034 First acceptance is possible at the first rising edge with rst_n high.

Verification
REQ-035 TREADY=1; ACT(bg1,bank2,row 0x1ABCD), RD, RD, PRE(PALL) back-to-back -> one beat, TVALID the cycle after PRE; slot0 = 0x00D5E6B2; slot3 type 1 with bit7=1; data 0.
REQ-036 Two WR commands with data A and B -> beat1: slot0 WR, slots1-3 zero, data A; cmd_ready low one cycle; beat2: slot0 WR, data B.
REQ-037 FLUSH_TIMEOUT=16; single REF then idle -> beat with slot0=5 and the rest zero, TVALID 17 cycles after acceptance; no further beats.
REQ-038 TREADY=0; 8 commands -> beat1 held stable, beat2 in HOLD, cmd_ready=0; raise TREADY -> beats in order, beat_count=2.
REQ-039 rst_n pulsed low mid-HOLD, asynchronous to clk -> TVALID and beat_count 0 immediately; nothing emitted after release until new commands arrive.

Source files
------------

// File: rtl/instr_packer_if.sv
// Command-in / merged-beat-out bundle for instr_packer.
// slave is the packer's view; master is the command source and stream sink.
interface instr_packer_if #(
    parameter int BANK_WIDTH = 2,
    parameter int BG_WIDTH   = 2,
    parameter int ROW_WIDTH  = 17
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [2:0]            cmd_type;
    logic [BANK_WIDTH-1:0] cmd_bank;
    logic [BG_WIDTH-1:0]   cmd_bg;
    logic [ROW_WIDTH-1:0]  cmd_addr;
    logic [511:0]          cmd_wdata;
    logic                  cmd_last;
    logic [639:0]          M_AXIS_TDATA;
    logic                  M_AXIS_TVALID;
    logic                  M_AXIS_TREADY;

    modport master (
        output cmd_valid, cmd_type, cmd_bank, cmd_bg, cmd_addr, cmd_wdata, cmd_last,
        output M_AXIS_TREADY,
        input  cmd_ready, M_AXIS_TDATA, M_AXIS_TVALID
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_bank, cmd_bg, cmd_addr, cmd_wdata, cmd_last,
        input  M_AXIS_TREADY,
        output cmd_ready, M_AXIS_TDATA, M_AXIS_TVALID
    );
endinterface

// File: rtl/instr_packer.sv
// Packs up to four DRAM commands (and at most one write burst) into a 640-bit beat.
// A closed beat waits in HOLD while the single-entry output register is still occupied.
module instr_packer #(
    parameter int BG_WIDTH      = 2,
    parameter int BANK_WIDTH    = 2,
    parameter int ROW_WIDTH     = 17,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_packer_if.slave bus,
    output logic [31:0]   beat_count
);
    localparam int SLOT_W = 32;
    localparam int DATA_W = 512;
    localparam int ASM_W  = 4 * SLOT_W;
    localparam int BEAT_W = ASM_W + DATA_W;
    localparam int IDLE_W = (FLUSH_TIMEOUT < 1) ? 1 : $clog2(FLUSH_TIMEOUT + 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(FLUSH_TIMEOUT);
    localparam logic [IDLE_W-1:0] IDLE_ONE = IDLE_W'(1);
    localparam logic [2:0] CMD_WR = 3'd4;

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    function automatic logic [SLOT_W-1:0] make_slot(
        input logic [2:0]            ctype,
        input logic [BANK_WIDTH-1:0] bank,
        input logic [BG_WIDTH-1:0]   bg,
        input logic [ROW_WIDTH-1:0]  addr
    );
        logic [SLOT_W-1:0] s;
        s = '0;
        s[2:0] = ctype;
        s[3 +: BANK_WIDTH] = bank;
        s[3 + BANK_WIDTH +: BG_WIDTH] = bg;
        s[3 + BANK_WIDTH + BG_WIDTH +: ROW_WIDTH] = addr;
        return s;
    endfunction

    state_t              state_r,      state_nx_s;
    logic [ASM_W-1:0]    slots_r,      slots_nx_s;
    logic [DATA_W-1:0]   wdata_r,      wdata_nx_s;
    logic [2:0]          cnt_r,        cnt_nx_s;
    logic                has_wr_r,     has_wr_nx_s;
    logic [IDLE_W-1:0]   idle_r,       idle_nx_s;
    logic                tvalid_r,     tvalid_nx_s;
    logic [BEAT_W-1:0]   tdata_r,      tdata_nx_s;
    logic [31:0]         beat_count_r, beat_count_nx_s;

    logic                wr_req_s;
    logic                cmd_ready_s;
    logic                accept_s;
    logic                out_free_s;
    logic [SLOT_W-1:0]   new_slot_s;
    logic [ASM_W-1:0]    asm_slots_s;
    logic [DATA_W-1:0]   asm_wdata_s;
    logic [2:0]          asm_cnt_s;
    logic                asm_has_wr_s;
    logic                conflict_s;
    logic                timeout_s;
    logic                close_s;

    assign bus.cmd_ready     = cmd_ready_s;
    assign bus.M_AXIS_TVALID = tvalid_r;
    assign bus.M_AXIS_TDATA  = tdata_r;
    assign beat_count        = beat_count_r;

    // Handshake decode: a second WR is refused so each beat carries one burst.
    always_comb begin
        wr_req_s    = bus.cmd_valid && (bus.cmd_type == CMD_WR);
        cmd_ready_s = 1'b0;
        if (rst_n && (state_r == ST_ACC) && !(wr_req_s && has_wr_r)) begin
            cmd_ready_s = 1'b1;
        end else begin
            cmd_ready_s = 1'b0;
        end
        accept_s   = bus.cmd_valid && cmd_ready_s;
        out_free_s = !tvalid_r || bus.M_AXIS_TREADY;
        new_slot_s = make_slot(bus.cmd_type, bus.cmd_bank, bus.cmd_bg, bus.cmd_addr);
    end

    // Assembly as it would look including this cycle's accepted command, plus close causes.
    always_comb begin
        asm_slots_s  = slots_r;
        asm_wdata_s  = wdata_r;
        asm_cnt_s    = cnt_r;
        asm_has_wr_s = has_wr_r;
        if (accept_s) begin
            case (cnt_r)
                3'd0:    asm_slots_s[SLOT_W*0 +: SLOT_W] = new_slot_s;
                3'd1:    asm_slots_s[SLOT_W*1 +: SLOT_W] = new_slot_s;
                3'd2:    asm_slots_s[SLOT_W*2 +: SLOT_W] = new_slot_s;
                3'd3:    asm_slots_s[SLOT_W*3 +: SLOT_W] = new_slot_s;
                default: asm_slots_s = slots_r;
            endcase
            asm_cnt_s = cnt_r + 3'd1;
            if (wr_req_s) begin
                asm_wdata_s  = bus.cmd_wdata;
                asm_has_wr_s = 1'b1;
            end else begin
                asm_wdata_s  = wdata_r;
                asm_has_wr_s = has_wr_r;
            end
        end else begin
            asm_cnt_s = cnt_r;
        end
        conflict_s = (state_r == ST_ACC) && wr_req_s && has_wr_r && (cnt_r != 3'd0);
        // Acceptance beats a simultaneous timeout.
        timeout_s  = (FLUSH_TIMEOUT != 0) && (state_r == ST_ACC) && !accept_s &&
                     (cnt_r != 3'd0) && (idle_r == IDLE_MAX);
        close_s    = (accept_s && ((asm_cnt_s == 3'd4) || bus.cmd_last)) || conflict_s || timeout_s;
    end

    // Next-state: beat closure, HOLD release, output register and beat counter.
    always_comb begin
        state_nx_s      = state_r;
        slots_nx_s      = slots_r;
        wdata_nx_s      = wdata_r;
        cnt_nx_s        = cnt_r;
        has_wr_nx_s     = has_wr_r;
        idle_nx_s       = idle_r;
        tvalid_nx_s     = tvalid_r;
        tdata_nx_s      = tdata_r;
        beat_count_nx_s = beat_count_r;

        if (tvalid_r && bus.M_AXIS_TREADY) begin
            tvalid_nx_s     = 1'b0;
            beat_count_nx_s = beat_count_r + 32'd1;
        end else begin
            tvalid_nx_s     = tvalid_r;
            beat_count_nx_s = beat_count_r;
        end

        case (state_r)
            ST_ACC: begin
                if (close_s && out_free_s) begin
                    tvalid_nx_s = 1'b1;
                    tdata_nx_s  = {asm_wdata_s, asm_slots_s};
                    slots_nx_s  = '0;
                    wdata_nx_s  = '0;
                    cnt_nx_s    = 3'd0;
                    has_wr_nx_s = 1'b0;
                    idle_nx_s   = '0;
                end else if (close_s) begin
                    state_nx_s  = ST_HOLD;
                    slots_nx_s  = asm_slots_s;
                    wdata_nx_s  = asm_wdata_s;
                    cnt_nx_s    = asm_cnt_s;
                    has_wr_nx_s = asm_has_wr_s;
                    idle_nx_s   = '0;
                end else begin
                    slots_nx_s  = asm_slots_s;
                    wdata_nx_s  = asm_wdata_s;
                    cnt_nx_s    = asm_cnt_s;
                    has_wr_nx_s = asm_has_wr_s;
                    if (accept_s) begin
                        idle_nx_s = '0;
                    end else if ((cnt_r != 3'd0) && (idle_r < IDLE_MAX)) begin
                        idle_nx_s = idle_r + IDLE_ONE;
                    end else begin
                        idle_nx_s = idle_r;
                    end
                end
            end
            ST_HOLD: begin
                if (out_free_s) begin
                    state_nx_s  = ST_ACC;
                    tvalid_nx_s = 1'b1;
                    tdata_nx_s  = {wdata_r, slots_r};
                    slots_nx_s  = '0;
                    wdata_nx_s  = '0;
                    cnt_nx_s    = 3'd0;
                    has_wr_nx_s = 1'b0;
                    idle_nx_s   = '0;
                end else begin
                    state_nx_s  = ST_HOLD;
                end
            end
            default: begin
                state_nx_s  = ST_ACC;
                slots_nx_s  = '0;
                wdata_nx_s  = '0;
                cnt_nx_s    = 3'd0;
                has_wr_nx_s = 1'b0;
                idle_nx_s   = '0;
            end
        endcase
    end

    // State and datapath registers; reset drops any partial or pending beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_ACC;
            slots_r      <= '0;
            wdata_r      <= '0;
            cnt_r        <= 3'd0;
            has_wr_r     <= 1'b0;
            idle_r       <= '0;
            tvalid_r     <= 1'b0;
            tdata_r      <= '0;
            beat_count_r <= 32'd0;
        end else begin
            state_r      <= state_nx_s;
            slots_r      <= slots_nx_s;
            wdata_r      <= wdata_nx_s;
            cnt_r        <= cnt_nx_s;
            has_wr_r     <= has_wr_nx_s;
            idle_r       <= idle_nx_s;
            tvalid_r     <= tvalid_nx_s;
            tdata_r      <= tdata_nx_s;
            beat_count_r <= beat_count_nx_s;
        end
    end
endmodule

// File: tb/tb_instr_packer.sv
// Directed bench for instr_packer: expected beats are queued as commands are driven
// and compared by a monitor when each beat is handed off.
module tb_instr_packer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] beat_count;

    instr_packer_if #(.BANK_WIDTH(2), .BG_WIDTH(2), .ROW_WIDTH(17)) bus ();

    instr_packer #(
        .BG_WIDTH(2), .BANK_WIDTH(2), .ROW_WIDTH(17), .FLUSH_TIMEOUT(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .beat_count(beat_count)
    );

    always #5 clk = ~clk;

    logic [639:0] exp_q[$];
    logic [639:0] mon_exp;
    int n_cmp = 0;
    int n_err = 0;
    int exp_bc = 0;

    task automatic chk(input string tag, input logic [639:0] obs, input logic [639:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mk_slot(input logic [2:0] t, input logic [1:0] bk,
                                            input logic [1:0] bg, input logic [16:0] a);
        return {8'h00, a, bg, bk, t};
    endfunction

    function automatic logic [639:0] mk_beat(input logic [511:0] d, input logic [31:0] s0,
                                             input logic [31:0] s1, input logic [31:0] s2,
                                             input logic [31:0] s3);
        return {d, s3, s2, s1, s0};
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    // Drive one command and hold it until accepted; returns stall cycles.
    task automatic send(input logic [2:0] t, input logic [1:0] bk, input logic [1:0] bg,
                        input logic [16:0] a, input logic [511:0] d, input logic l,
                        output int waits);
        bit accepted;
        accepted = 1'b0;
        waits = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_type  = t;
        bus.cmd_bank  = bk;
        bus.cmd_bg    = bg;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_last  = l;
        for (int i = 0; i < 200 && !accepted; i++) begin
            @(negedge clk);
            if (bus.cmd_ready) accepted = 1'b1;
            else waits++;
            @(posedge clk);
            #1;
        end
        bus.cmd_valid = 1'b0;
        bus.cmd_last  = 1'b0;
        if (!accepted) chk("accept_timeout", 640'(accepted), 640'(1'b1));
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 200 && (exp_q.size() != 0 || bus.M_AXIS_TVALID); i++) begin
            @(posedge clk);
            #1;
        end
        chk("drain", 640'(exp_q.size()), 640'(0));
    endtask

    // Scoreboard monitor: a beat moves on the coming edge when VALID and READY are both high.
    always @(negedge clk) begin
        if (rst_n && bus.M_AXIS_TVALID && bus.M_AXIS_TREADY) begin
            chk("beat_pending", 640'(exp_q.size() != 0), 640'(1'b1));
            if (exp_q.size() != 0) begin
                mon_exp = exp_q.pop_front();
                chk("beat_data", bus.M_AXIS_TDATA, mon_exp);
            end
        end
    end

    initial begin
        int w;
        int wsum;
        int k;
        logic [511:0] da, db;
        logic [31:0] rs[8];

        rst_n = 1'b0;
        bus.cmd_valid = 1'b1;
        bus.cmd_type = 3'd3;
        bus.cmd_bank = 2'd0;
        bus.cmd_bg = 2'd0;
        bus.cmd_addr = 17'd0;
        bus.cmd_wdata = '0;
        bus.cmd_last = 1'b0;
        bus.M_AXIS_TREADY = 1'b1;
        #2;
        chk("rst_tvalid", 640'(bus.M_AXIS_TVALID), 640'(1'b0));
        chk("rst_tdata", bus.M_AXIS_TDATA, 640'(0));
        chk("rst_beat_count", 640'(beat_count), 640'(0));
        chk("rst_cmd_ready", 640'(bus.cmd_ready), 640'(1'b0));
        bus.cmd_valid = 1'b0;
        #6 rst_n = 1'b1;

        // ACT/RD/RD/PRE(PALL) back-to-back fill one beat.
        exp_q.push_back(mk_beat(512'd0, 32'h00D5E6B2, mk_slot(3'd3, 2'd2, 2'd1, 17'h00010),
                                mk_slot(3'd3, 2'd2, 2'd1, 17'h00018), mk_slot(3'd1, 2'd0, 2'd0, 17'h00001)));
        exp_bc++;
        wsum = 0;
        send(3'd2, 2'd2, 2'd1, 17'h1ABCD, rnd512(), 1'b0, w); wsum += w;
        send(3'd3, 2'd2, 2'd1, 17'h00010, rnd512(), 1'b0, w); wsum += w;
        send(3'd3, 2'd2, 2'd1, 17'h00018, rnd512(), 1'b0, w); wsum += w;
        send(3'd1, 2'd0, 2'd0, 17'h00001, rnd512(), 1'b0, w); wsum += w;
        chk("t1_no_stall", 640'(wsum), 640'(0));
        chk("t1_tvalid_latency", 640'(bus.M_AXIS_TVALID), 640'(1'b1));
        chk("t1_slot0", 640'(bus.M_AXIS_TDATA[31:0]), 640'(32'h00D5E6B2));
        chk("t1_slot3_type", 640'(bus.M_AXIS_TDATA[98:96]), 640'(3'd1));
        chk("t1_slot3_pall", 640'(bus.M_AXIS_TDATA[103]), 640'(1'b1));
        wait_drain();
        chk("t1_beat_count", 640'(beat_count), 640'(exp_bc));

        // Two writes: the second stalls one cycle and starts a fresh beat.
        da = rnd512();
        db = rnd512();
        exp_q.push_back(mk_beat(da, mk_slot(3'd4, 2'd1, 2'd0, 17'h00100), 32'd0, 32'd0, 32'd0));
        exp_q.push_back(mk_beat(db, mk_slot(3'd4, 2'd3, 2'd2, 17'h00200), 32'd0, 32'd0, 32'd0));
        exp_bc += 2;
        send(3'd4, 2'd1, 2'd0, 17'h00100, da, 1'b0, w);
        send(3'd4, 2'd3, 2'd2, 17'h00200, db, 1'b1, w);
        chk("t2_wr_stall", 640'(w), 640'(1));
        wait_drain();
        chk("t2_beat_count", 640'(beat_count), 640'(exp_bc));

        // Write in a middle slot; cmd_last closes a partial beat.
        da = rnd512();
        exp_q.push_back(mk_beat(da, mk_slot(3'd3, 2'd0, 2'd3, 17'h00ABC), mk_slot(3'd4, 2'd2, 2'd1, 17'h12345),
                                mk_slot(3'd3, 2'd1, 2'd0, 17'h00777), 32'd0));
        exp_bc++;
        send(3'd3, 2'd0, 2'd3, 17'h00ABC, rnd512(), 1'b0, w);
        send(3'd4, 2'd2, 2'd1, 17'h12345, da, 1'b0, w);
        send(3'd3, 2'd1, 2'd0, 17'h00777, rnd512(), 1'b1, w);
        wait_drain();

        // Lone REF closes by timeout 17 edges after acceptance.
        exp_q.push_back(mk_beat(512'd0, 32'd5, 32'd0, 32'd0, 32'd0));
        exp_bc++;
        send(3'd5, 2'd0, 2'd0, 17'd0, rnd512(), 1'b0, w);
        k = 0;
        for (int i = 0; i < 40 && !bus.M_AXIS_TVALID; i++) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("t3_timeout_latency", 640'(k), 640'(17));
        repeat (40) @(posedge clk);
        #1;
        chk("t3_no_extra_beats", 640'(beat_count), 640'(exp_bc));
        chk("t3_idle_tvalid", 640'(bus.M_AXIS_TVALID), 640'(1'b0));

        // Reserved type 7 and all-ones fields pass through.
        exp_q.push_back(mk_beat(512'd0, mk_slot(3'd7, 2'd3, 2'd3, 17'h1FFFF), 32'd0, 32'd0, 32'd0));
        exp_bc++;
        send(3'd7, 2'd3, 2'd3, 17'h1FFFF, rnd512(), 1'b1, w);
        wait_drain();
        chk("t3b_beat_count", 640'(beat_count), 640'(exp_bc));

        // Reset, then backpressure: beat1 held, beat2 parked in HOLD.
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        exp_bc = 0;
        chk("t4_reset_count", 640'(beat_count), 640'(0));
        bus.M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 8; i++) rs[i] = mk_slot(3'd3, 2'(i), 2'(i >> 2), 17'(16 * i + 3));
        exp_q.push_back(mk_beat(512'd0, rs[0], rs[1], rs[2], rs[3]));
        exp_q.push_back(mk_beat(512'd0, rs[4], rs[5], rs[6], rs[7]));
        exp_bc += 2;
        for (int i = 0; i < 8; i++) send(3'd3, 2'(i), 2'(i >> 2), 17'(16 * i + 3), rnd512(), 1'b0, w);
        chk("t4_hold_ready", 640'(bus.cmd_ready), 640'(1'b0));
        repeat (3) @(posedge clk);
        #1;
        chk("t4_held_valid", 640'(bus.M_AXIS_TVALID), 640'(1'b1));
        chk("t4_held_data", bus.M_AXIS_TDATA, mk_beat(512'd0, rs[0], rs[1], rs[2], rs[3]));
        bus.M_AXIS_TREADY = 1'b1;
        wait_drain();
        chk("t4_beat_count", 640'(beat_count), 640'(exp_bc));

        // Asynchronous reset mid-HOLD discards both pending beats.
        bus.M_AXIS_TREADY = 1'b0;
        for (int i = 0; i < 8; i++) send(3'd2, 2'(i), 2'd1, 17'(i + 100), rnd512(), 1'b0, w);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_rst_tvalid", 640'(bus.M_AXIS_TVALID), 640'(1'b0));
        chk("t5_rst_beat_count", 640'(beat_count), 640'(0));
        chk("t5_rst_tdata", bus.M_AXIS_TDATA, 640'(0));
        bus.cmd_valid = 1'b1;
        #1;
        chk("t5_rst_ready", 640'(bus.cmd_ready), 640'(1'b0));
        bus.cmd_valid = 1'b0;
        #11 rst_n = 1'b1;
        bus.M_AXIS_TREADY = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        chk("t5_nothing_after_reset", 640'(beat_count), 640'(0));
        chk("t5_idle_tvalid", 640'(bus.M_AXIS_TVALID), 640'(1'b0));
        exp_q.push_back(mk_beat(512'd0, mk_slot(3'd6, 2'd1, 2'd2, 17'h00042), 32'd0, 32'd0, 32'd0));
        send(3'd6, 2'd1, 2'd2, 17'h00042, rnd512(), 1'b1, w);
        wait_drain();
        chk("t5_resume_count", 640'(beat_count), 640'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
